// File: rtl/adc_sched.sv
// Conversion scheduler: periodic cstart generation, per-channel result capture
// and round-robin serialization onto a single valid/ready stream.
module adc_sched #(
  parameter int W_DATA   = 18,
  parameter int N_CHAN   = 6,
  parameter int W_PERIOD = 16,
  parameter int W_CHAN   = 3
) (
  input  logic                clk_in,
  input  logic                n_reset_in,
  input  logic                enable_in,
  input  logic [W_PERIOD-1:0] period_in,
  input  logic [N_CHAN-1:0]   chan_en_in,
  input  logic [N_CHAN-1:0]   data_valid_in,
  input  logic [W_DATA-1:0]   data_a_in,
  input  logic [W_DATA-1:0]   data_b_in,
  input  logic                ovr_clr_in,
  input  logic                ready_in,
  output logic                cstart_out,
  output logic [W_DATA-1:0]   data_out,
  output logic [W_CHAN-1:0]   chan_out,
  output logic                valid_out,
  output logic [N_CHAN-1:0]   overrun_out,
  output logic                skip_out,
  output logic                cycle_done_out
);

  logic [W_PERIOD-1:0] cnt_q, cnt_d;
  logic [W_PERIOD-1:0] per_eff;
  logic                tc, trig_go;
  logic [N_CHAN-1:0]   pend_q, pend_d, pend_keep;
  logic                done_q, done_d;
  logic [N_CHAN-1:0]   full_q, full_d;
  logic [W_DATA-1:0]   hold_q [N_CHAN];
  logic [W_DATA-1:0]   hold_d [N_CHAN];
  logic [N_CHAN-1:0]   ovr_q, ovr_d, ovr_set;
  logic                vld_q, vld_d;
  logic [W_DATA-1:0]   dout_q, dout_d;
  logic [W_CHAN-1:0]   chan_q, chan_d;
  logic [W_CHAN-1:0]   rr_q, rr_d;

  logic [N_CHAN-1:0]   cap, avail;
  logic                free, found, take;
  logic [W_CHAN-1:0]   sel;
  logic [W_DATA-1:0]   dout_sel, word;
  int                  idx;

  // Timer and trigger / pending bookkeeping
  always_comb begin
    per_eff   = (period_in < W_PERIOD'(2)) ? W_PERIOD'(2) : period_in;
    tc        = enable_in && (cnt_q == per_eff - W_PERIOD'(1));
    cnt_d     = (!enable_in || tc) ? '0 : cnt_q + W_PERIOD'(1);
    cap       = data_valid_in & chan_en_in;
    trig_go   = tc && (pend_q == '0);
    pend_keep = pend_q & ~data_valid_in & chan_en_in;
    pend_d    = trig_go ? chan_en_in : pend_keep;
    // Only a capture that empties pending counts; a pure mask release does not.
    done_d    = (pend_q != '0) && (pend_keep == '0) && ((pend_q & cap) != '0);
  end

  // Round-robin search over held words plus words arriving this cycle
  always_comb begin
    free  = !vld_q || ready_in;
    avail = full_q | cap;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < N_CHAN; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_CHAN) idx = idx - N_CHAN;
      if (!found && avail[idx]) begin
        found = 1'b1;
        sel   = W_CHAN'(idx);
      end
    end
    take = free && found;
  end

  always_comb begin
    full_d   = full_q;
    ovr_set  = '0;
    dout_sel = '0;
    word     = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      hold_d[i] = hold_q[i];
      word      = (i < N_CHAN/2) ? data_a_in : data_b_in;
      if (take && (sel == W_CHAN'(i))) begin
        // Held word leaves first; a same-cycle arrival refills the slot.
        dout_sel  = full_q[i] ? hold_q[i] : word;
        full_d[i] = full_q[i] && cap[i];
        if (cap[i]) hold_d[i] = word;
      end else if (cap[i]) begin
        hold_d[i]  = word;
        full_d[i]  = 1'b1;
        ovr_set[i] = full_q[i];
      end
    end
    ovr_d = (ovr_q & ~{N_CHAN{ovr_clr_in}}) | ovr_set;
  end

  always_comb begin
    vld_d  = vld_q;
    dout_d = dout_q;
    chan_d = chan_q;
    rr_d   = rr_q;
    if (free) begin
      vld_d = found;
      if (found) begin
        dout_d = dout_sel;
        chan_d = sel;
        rr_d   = (sel == W_CHAN'(N_CHAN-1)) ? '0 : sel + W_CHAN'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      cnt_q  <= '0;
      pend_q <= '0;
      done_q <= 1'b0;
      full_q <= '0;
      ovr_q  <= '0;
      vld_q  <= 1'b0;
      dout_q <= '0;
      chan_q <= '0;
      rr_q   <= '0;
      for (int i = 0; i < N_CHAN; i++) hold_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      done_q <= done_d;
      full_q <= full_d;
      ovr_q  <= ovr_d;
      vld_q  <= vld_d;
      dout_q <= dout_d;
      chan_q <= chan_d;
      rr_q   <= rr_d;
      for (int i = 0; i < N_CHAN; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign cstart_out     = trig_go;
  assign skip_out       = tc && (pend_q != '0);
  assign cycle_done_out = done_q;
  assign data_out       = dout_q;
  assign chan_out       = chan_q;
  assign valid_out      = vld_q;
  assign overrun_out    = ovr_q;

endmodule

// File: tb/tb_adc_sched.sv
// Scoreboard bench for adc_sched: an ADC model answers each cstart and pushes
// the expected (channel, word) pairs; a negedge monitor pops them off the stream.
module tb_adc_sched;

  logic        clk;
  logic        n_reset;
  logic        enable;
  logic [15:0] period;
  logic [5:0]  chan_en;
  logic [5:0]  data_valid;
  logic [17:0] data_a, data_b;
  logic        ovr_clr, ready;
  logic        cstart, valid_o, skip, done;
  logic [17:0] data_o;
  logic [2:0]  chan_o;
  logic [5:0]  overrun;

  adc_sched dut (
    .clk_in(clk), .n_reset_in(n_reset), .enable_in(enable), .period_in(period),
    .chan_en_in(chan_en), .data_valid_in(data_valid), .data_a_in(data_a),
    .data_b_in(data_b), .ovr_clr_in(ovr_clr), .ready_in(ready),
    .cstart_out(cstart), .data_out(data_o), .chan_out(chan_o), .valid_out(valid_o),
    .overrun_out(overrun), .skip_out(skip), .cycle_done_out(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0;
  int cstart_cnt = 0, skip_cnt = 0, done_cnt = 0;
  logic [20:0] q[$];
  logic [17:0] vals [6];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cstart) cstart_cnt++;
    if (skip)   skip_cnt++;
    if (done)   done_cnt++;
    if (valid_o && ready) begin
      if (q.size() == 0) chk("unexpected_word", q.size(), 1);
      else begin
        logic [20:0] e;
        e = q.pop_front();
        chk("chan", int'(chan_o), int'(e[20:18]));
        chk("data", int'(data_o), int'(e[17:0]));
      end
    end
  end

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    t0 = cyc;
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    q.delete();
    release_reset();
  endtask

  task automatic goto_cycle(input int k);
    while (cyc - t0 < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cstart(input int budget, output int c);
    c = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (cstart) begin
        c = cyc - t0;
        break;
      end
    end
    if (c < 0) chk("cstart_timeout", c, 0);
  endtask

  // ADC model: one valid per cycle, channel 0 first; bus A for 0..2, bus B for 3..5
  task automatic conv(input logic [5:0] deliver);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      data_valid = deliver[i] ? (6'd1 << i) : 6'd0;
      if (i < 3) data_a = vals[i];
      else       data_b = vals[i];
      if (deliver[i] && chan_en[i]) q.push_back({3'(i), vals[i]});
    end
    @(posedge clk);
    #1 data_valid = '0;
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1 n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic set_base();
    vals[0] = 18'd1111; vals[1] = 18'd2222; vals[2] = 18'd3333;
    vals[3] = 18'd4444; vals[4] = 18'd5555; vals[5] = 18'd6666;
  endtask

  initial begin
    int c, n, d0, s0, c0;
    n_reset = 1'b0; enable = 1'b1; period = 16'd200; chan_en = 6'h3f;
    data_valid = '0; data_a = '0; data_b = '0; ovr_clr = 1'b0; ready = 1'b1;
    set_base();

    // Basic run
    do_reset();
    d0 = done_cnt; s0 = skip_cnt; c0 = cstart_cnt;
    wait_cstart(400, c); chk("basic_cstart1", c, 199);
    conv(6'h3f);
    wait_cstart(400, c); chk("basic_cstart2", c, 399);
    conv(6'h3f);
    drain(50, n);
    repeat (3) @(posedge clk);
    #1;
    chk("basic_done", done_cnt - d0, 2);
    chk("basic_skip", skip_cnt - s0, 0);
    chk("basic_cstarts", cstart_cnt - c0, 2);
    chk("basic_overrun", int'(overrun), 0);

    // Backpressure
    do_reset();
    ready = 1'b0;
    wait_cstart(400, c); chk("bp_cstart", c, 199);
    conv(6'h3f);
    for (int k = 207; k <= 220; k++) begin
      goto_cycle(k);
      @(negedge clk);
      chk("bp_valid", int'(valid_o), 1);
      chk("bp_data", int'(data_o), 1111);
      chk("bp_chan", int'(chan_o), 0);
    end
    goto_cycle(221);
    ready = 1'b1;
    drain(50, n);
    chk("bp_throughput", n, 6);

    // Masking
    period = 16'd50; chan_en = 6'b101010;
    do_reset();
    d0 = done_cnt;
    wait_cstart(100, c); chk("mask_cstart", c, 49);
    conv(6'h3f);
    drain(50, n);
    repeat (3) @(posedge clk);
    #1;
    chk("mask_done", done_cnt - d0, 1);
    chk("mask_overrun", int'(overrun), 0);

    // Overrun: the first word of the first conversion parks in the output
    // register, so channel 0 needs a third conversion to overrun its hold slot.
    chan_en = 6'h3f; ready = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wait_cstart(100, c);
      set_base();
      if (k == 2) begin
        vals[0] = 18'd7777; vals[1] = 18'd8882; vals[2] = 18'd8883;
        vals[3] = 18'd8884; vals[4] = 18'd8885; vals[5] = 18'd8886;
      end
      conv(6'h3f);
    end
    chk("ovr_flags", int'(overrun), 63);
    q.delete();
    q.push_back({3'd0, 18'd1111});
    for (int i = 1; i < 6; i++) q.push_back({3'(i), vals[i]});
    q.push_back({3'd0, 18'd7777});
    ready = 1'b1;
    drain(50, n);
    chk("ovr_sticky", int'(overrun), 63);
    @(posedge clk);
    #1 ovr_clr = 1'b1;
    @(posedge clk);
    #1 ovr_clr = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", int'(overrun), 0);

    // Skip: channel 5 never answers
    period = 16'd10;
    do_reset();
    d0 = done_cnt;
    wait_cstart(20, c); chk("skip_cstart1", c, 9);
    conv(6'b011111);
    s0 = skip_cnt; c0 = cstart_cnt;
    goto_cycle(45);
    chk("skip_pulses", skip_cnt - s0, 3);
    chk("skip_no_cstart", cstart_cnt - c0, 0);
    chan_en = 6'b011111;
    wait_cstart(20, c); chk("skip_resume", c, 49);
    chk("skip_no_done", done_cnt - d0, 0);
    drain(20, n);

    // Reset mid-drain
    period = 16'd50; chan_en = 6'h3f; ready = 1'b0;
    do_reset();
    wait_cstart(100, c);
    conv(6'h3f);
    @(negedge clk);
    chk("pre_rst_valid", int'(valid_o), 1);
    #2 n_reset = 1'b0;
    #1;
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_data", int'(data_o), 0);
    chk("rst_chan", int'(chan_o), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_pulses", int'({cstart, skip, done}), 0);
    q.delete();
    release_reset();
    ready = 1'b1;
    wait_cstart(100, c); chk("rst_cstart", c, 49);
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
